// File: rtl/reorder_buffer_pkg.sv
// Shared types and constants for the reorder buffer and its query ports.
// The ALU op encodings are kept here so branch result semantics stay aligned with the RS.
package reorder_buffer_pkg;

    localparam int ROB_WIDTH_DEF = 4;

    typedef enum logic [1:0] {
        TYPE_REG  = 2'd0,
        TYPE_BR   = 2'd1,
        TYPE_ST   = 2'd2,
        TYPE_EXIT = 2'd3
    } rob_type_e;

    // Branch ops write val[0] = 1 when the branch is actually taken.
    typedef enum logic [2:0] {
        ALU_EQ  = 3'd0,
        ALU_NE  = 3'd1,
        ALU_LT  = 3'd2,
        ALU_GE  = 3'd3,
        ALU_LTU = 3'd4,
        ALU_GEU = 3'd5
    } alu_op_e;

    typedef struct packed {
        logic        valid;
        logic        ready;
        rob_type_e   typ;
        logic [4:0]  rd;
        logic [31:0] val;
        logic        pred_taken;
        logic [31:0] alt_pc;
    } rob_entry_t;

    function automatic logic is_mispredict(input rob_entry_t e);
        return (e.typ == TYPE_BR) && (e.val[0] != e.pred_taken);
    endfunction

endpackage

// File: rtl/rob_query_port.sv
// Resolves one operand tag into ready/value, bypassing same-cycle writebacks.
module rob_query_port
    import reorder_buffer_pkg::*;
#(
    parameter int ROB_WIDTH = ROB_WIDTH_DEF
) (
    input  logic [ROB_WIDTH-1:0]      query_tag,
    input  logic [(1<<ROB_WIDTH)-1:0] entry_ready,
    input  logic [31:0]               entry_val [1<<ROB_WIDTH],
    input  logic                      rs_flag,
    input  logic [31:0]               rs_val,
    input  logic [ROB_WIDTH-1:0]      rs_dest,
    input  logic                      lsb_flag,
    input  logic [31:0]               lsb_val,
    input  logic [ROB_WIDTH-1:0]      lsb_dest,
    output logic                      query_ready,
    output logic [31:0]               query_val
);

    always_comb begin
        query_ready = entry_ready[query_tag];
        query_val   = entry_val[query_tag];
        if (rs_flag && (rs_dest == query_tag)) begin
            query_ready = 1'b1;
            query_val   = rs_val;
        end else if (lsb_flag && (lsb_dest == query_tag)) begin
            query_ready = 1'b1;
            query_val   = lsb_val;
        end
    end

endmodule

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order retire of out-of-order results, with
// branch-mispredict flush and operand tag resolution for issue logic.
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int ROB_WIDTH = ROB_WIDTH_DEF
) (
    input  logic                 clockIn,
    input  logic                 resetIn,
    input  logic                 readyIn,
    input  logic                 issueFlag,
    input  logic [1:0]           issueType,
    input  logic [4:0]           issueRd,
    input  logic                 issuePredTaken,
    input  logic [31:0]          issueAltPc,
    input  logic                 issueReady,
    input  logic [31:0]          issueVal,
    output logic [ROB_WIDTH-1:0] tailTag,
    output logic                 full,
    input  logic [ROB_WIDTH-1:0] queryJ,
    input  logic [ROB_WIDTH-1:0] queryK,
    output logic                 queryJReady,
    output logic                 queryKReady,
    output logic [31:0]          queryJVal,
    output logic [31:0]          queryKVal,
    input  logic                 rsFlag,
    input  logic [31:0]          rsVal,
    input  logic [ROB_WIDTH-1:0] rsDest,
    input  logic                 lsbFlag,
    input  logic [31:0]          lsbVal,
    input  logic [ROB_WIDTH-1:0] lsbDest,
    output logic                 commitFlag,
    output logic [1:0]           commitType,
    output logic [4:0]           commitRd,
    output logic [31:0]          commitVal,
    output logic [ROB_WIDTH-1:0] commitTag,
    output logic                 flushFlag,
    output logic [31:0]          flushPc,
    output logic                 exitFlag
);

    localparam int ROB_SIZE = 1 << ROB_WIDTH;

    rob_entry_t           entries_q [ROB_SIZE];
    rob_entry_t           entries_d [ROB_SIZE];
    logic [ROB_WIDTH-1:0] head_q, head_d;
    logic [ROB_WIDTH-1:0] tail_q, tail_d;
    logic [ROB_WIDTH:0]   count_q, count_d;

    logic                 commit_flag_q, commit_flag_d;
    logic [1:0]           commit_type_q, commit_type_d;
    logic [4:0]           commit_rd_q, commit_rd_d;
    logic [31:0]          commit_val_q, commit_val_d;
    logic [ROB_WIDTH-1:0] commit_tag_q, commit_tag_d;
    logic                 flush_flag_q, flush_flag_d;
    logic [31:0]          flush_pc_q, flush_pc_d;
    logic                 exit_flag_q, exit_flag_d;

    rob_entry_t           head_entry;
    logic                 is_full;
    logic                 alloc;
    logic                 commit_fire;
    logic                 mispredict;

    logic [ROB_SIZE-1:0]  entry_ready;
    logic [31:0]          entry_val [ROB_SIZE];

    assign head_entry  = entries_q[head_q];
    // Pre-commit count: a slot freed this cycle is not reusable until the next one.
    assign is_full     = (count_q == (ROB_WIDTH+1)'(ROB_SIZE));
    assign alloc       = readyIn && issueFlag && !is_full;
    assign commit_fire = readyIn && head_entry.valid && head_entry.ready && !flush_flag_q;
    assign mispredict  = commit_fire && is_mispredict(head_entry);

    always_comb begin
        entries_d     = entries_q;
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;
        commit_flag_d = commit_flag_q;
        commit_type_d = commit_type_q;
        commit_rd_d   = commit_rd_q;
        commit_val_d  = commit_val_q;
        commit_tag_d  = commit_tag_q;
        flush_flag_d  = flush_flag_q;
        flush_pc_d    = flush_pc_q;
        exit_flag_d   = exit_flag_q;

        if (readyIn) begin
            commit_flag_d = commit_fire;
            flush_flag_d  = mispredict;
            if (commit_fire) begin
                commit_type_d = head_entry.typ;
                commit_rd_d   = head_entry.rd;
                commit_val_d  = head_entry.val;
                commit_tag_d  = head_q;
                if (head_entry.typ == TYPE_EXIT) begin
                    exit_flag_d = 1'b1;
                end
            end

            if (mispredict) begin
                flush_pc_d = head_entry.alt_pc;
                for (int i = 0; i < ROB_SIZE; i++) begin
                    entries_d[i].valid = 1'b0;
                    entries_d[i].ready = 1'b0;
                end
                head_d  = '0;
                tail_d  = '0;
                count_d = '0;
            end else begin
                // rs is applied last so it wins a same-tag collision with lsb.
                if (lsbFlag && entries_q[lsbDest].valid) begin
                    entries_d[lsbDest].ready = 1'b1;
                    entries_d[lsbDest].val   = lsbVal;
                end
                if (rsFlag && entries_q[rsDest].valid) begin
                    entries_d[rsDest].ready = 1'b1;
                    entries_d[rsDest].val   = rsVal;
                end
                if (alloc) begin
                    entries_d[tail_q].valid      = 1'b1;
                    entries_d[tail_q].ready      = issueReady;
                    entries_d[tail_q].typ        = rob_type_e'(issueType);
                    entries_d[tail_q].rd         = issueRd;
                    entries_d[tail_q].val        = issueVal;
                    entries_d[tail_q].pred_taken = issuePredTaken;
                    entries_d[tail_q].alt_pc     = issueAltPc;
                    tail_d = tail_q + 1'b1;
                end
                if (commit_fire) begin
                    entries_d[head_q].valid = 1'b0;
                    entries_d[head_q].ready = 1'b0;
                    head_d = head_q + 1'b1;
                end
                count_d = count_q + {{ROB_WIDTH{1'b0}}, alloc} - {{ROB_WIDTH{1'b0}}, commit_fire};
            end
        end
    end

    always_ff @(posedge clockIn) begin
        if (!resetIn) begin
            for (int i = 0; i < ROB_SIZE; i++) begin
                entries_q[i] <= '0;
            end
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            commit_flag_q <= 1'b0;
            commit_type_q <= '0;
            commit_rd_q   <= '0;
            commit_val_q  <= '0;
            commit_tag_q  <= '0;
            flush_flag_q  <= 1'b0;
            flush_pc_q    <= '0;
            exit_flag_q   <= 1'b0;
        end else begin
            entries_q     <= entries_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            commit_flag_q <= commit_flag_d;
            commit_type_q <= commit_type_d;
            commit_rd_q   <= commit_rd_d;
            commit_val_q  <= commit_val_d;
            commit_tag_q  <= commit_tag_d;
            flush_flag_q  <= flush_flag_d;
            flush_pc_q    <= flush_pc_d;
            exit_flag_q   <= exit_flag_d;
        end
    end

    always_comb begin
        for (int i = 0; i < ROB_SIZE; i++) begin
            entry_ready[i] = entries_q[i].valid && entries_q[i].ready;
            entry_val[i]   = entries_q[i].val;
        end
    end

    rob_query_port #(.ROB_WIDTH(ROB_WIDTH)) u_query_j (
        .query_tag   (queryJ),
        .entry_ready (entry_ready),
        .entry_val   (entry_val),
        .rs_flag     (rsFlag),
        .rs_val      (rsVal),
        .rs_dest     (rsDest),
        .lsb_flag    (lsbFlag),
        .lsb_val     (lsbVal),
        .lsb_dest    (lsbDest),
        .query_ready (queryJReady),
        .query_val   (queryJVal)
    );

    rob_query_port #(.ROB_WIDTH(ROB_WIDTH)) u_query_k (
        .query_tag   (queryK),
        .entry_ready (entry_ready),
        .entry_val   (entry_val),
        .rs_flag     (rsFlag),
        .rs_val      (rsVal),
        .rs_dest     (rsDest),
        .lsb_flag    (lsbFlag),
        .lsb_val     (lsbVal),
        .lsb_dest    (lsbDest),
        .query_ready (queryKReady),
        .query_val   (queryKVal)
    );

    assign tailTag    = tail_q;
    assign full       = is_full;
    assign commitFlag = commit_flag_q;
    assign commitType = commit_type_q;
    assign commitRd   = commit_rd_q;
    assign commitVal  = commit_val_q;
    assign commitTag  = commit_tag_q;
    assign flushFlag  = flush_flag_q;
    assign flushPc    = flush_pc_q;
    assign exitFlag   = exit_flag_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer with a commit scoreboard.
module tb_reorder_buffer;

    logic        clk;
    logic        resetIn, readyIn;
    logic        issueFlag, issuePredTaken, issueReady;
    logic [1:0]  issueType;
    logic [4:0]  issueRd;
    logic [31:0] issueAltPc, issueVal;
    logic [3:0]  tailTag;
    logic        full;
    logic [3:0]  queryJ, queryK;
    logic        queryJReady, queryKReady;
    logic [31:0] queryJVal, queryKVal;
    logic        rsFlag, lsbFlag;
    logic [31:0] rsVal, lsbVal;
    logic [3:0]  rsDest, lsbDest;
    logic        commitFlag, flushFlag, exitFlag;
    logic [1:0]  commitType;
    logic [4:0]  commitRd;
    logic [31:0] commitVal, flushPc;
    logic [3:0]  commitTag;

    typedef struct {
        logic [1:0]  typ;
        logic [4:0]  rd;
        logic [31:0] val;
        logic [3:0]  tag;
        logic        flush;
        logic [31:0] pc;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    reorder_buffer #(.ROB_WIDTH(4)) dut (
        .clockIn(clk), .resetIn(resetIn), .readyIn(readyIn),
        .issueFlag(issueFlag), .issueType(issueType), .issueRd(issueRd),
        .issuePredTaken(issuePredTaken), .issueAltPc(issueAltPc),
        .issueReady(issueReady), .issueVal(issueVal),
        .tailTag(tailTag), .full(full),
        .queryJ(queryJ), .queryK(queryK),
        .queryJReady(queryJReady), .queryKReady(queryKReady),
        .queryJVal(queryJVal), .queryKVal(queryKVal),
        .rsFlag(rsFlag), .rsVal(rsVal), .rsDest(rsDest),
        .lsbFlag(lsbFlag), .lsbVal(lsbVal), .lsbDest(lsbDest),
        .commitFlag(commitFlag), .commitType(commitType), .commitRd(commitRd),
        .commitVal(commitVal), .commitTag(commitTag),
        .flushFlag(flushFlag), .flushPc(flushPc), .exitFlag(exitFlag)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout compared=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic expect_commit(input logic [1:0] t, input logic [4:0] rd, input logic [31:0] v,
                                 input logic [3:0] tag, input logic fl, input logic [31:0] pc);
        exp_t e;
        e.typ = t; e.rd = rd; e.val = v; e.tag = tag; e.flush = fl; e.pc = pc;
        exp_q.push_back(e);
    endtask

    task automatic do_issue(input logic [1:0] t, input logic [4:0] rd, input logic pred,
                            input logic [31:0] alt, input logic rdy, input logic [31:0] v);
        issueFlag = 1'b1; issueType = t; issueRd = rd; issuePredTaken = pred;
        issueAltPc = alt; issueReady = rdy; issueVal = v;
        tick();
        issueFlag = 1'b0; issueReady = 1'b0;
    endtask

    task automatic do_rs(input logic [3:0] tag, input logic [31:0] v);
        rsFlag = 1'b1; rsDest = tag; rsVal = v;
        tick();
        rsFlag = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 20; i++) begin
            if (exp_q.size() == 0) break;
            tick();
        end
        tick();
        chk(name, exp_q.size(), 0);
    endtask

    task automatic do_reset();
        resetIn = 1'b0;
        tick();
        resetIn = 1'b1;
    endtask

    // Scoreboard monitor: every commit pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (commitFlag) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_commit actual tag=%0d required none", commitTag);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (commitType !== e.typ || commitRd !== e.rd || commitVal !== e.val ||
                    commitTag !== e.tag || flushFlag !== e.flush ||
                    (e.flush && flushPc !== e.pc)) begin
                    n_fail++;
                    $display("FAIL commit actual typ=%0d rd=%0d val=%h tag=%0d fl=%b pc=%h required typ=%0d rd=%0d val=%h tag=%0d fl=%b pc=%h",
                             commitType, commitRd, commitVal, commitTag, flushFlag, flushPc,
                             e.typ, e.rd, e.val, e.tag, e.flush, e.pc);
                end
            end
        end else if (flushFlag) begin
            n_cmp++;
            n_fail++;
            $display("FAIL flush_without_commit actual=1 required=0");
        end
    end

    initial begin
        resetIn = 1'b0; readyIn = 1'b1;
        issueFlag = 1'b0; issueType = 2'd0; issueRd = 5'd0; issuePredTaken = 1'b0;
        issueAltPc = 32'd0; issueReady = 1'b0; issueVal = 32'd0;
        queryJ = 4'd0; queryK = 4'd0;
        rsFlag = 1'b0; rsVal = 32'd0; rsDest = 4'd0;
        lsbFlag = 1'b0; lsbVal = 32'd0; lsbDest = 4'd0;
        tick();
        tick();
        chk("rst_commitFlag", commitFlag, 0);
        chk("rst_flushFlag", flushFlag, 0);
        chk("rst_exitFlag", exitFlag, 0);
        chk("rst_full", full, 0);
        chk("rst_tailTag", tailTag, 0);
        resetIn = 1'b1;

        // Out-of-order writeback, in-order retire.
        do_issue(2'd0, 5'd1, 1'b0, 32'd0, 1'b0, 32'd0);
        do_issue(2'd0, 5'd2, 1'b0, 32'd0, 1'b0, 32'd0);
        do_issue(2'd0, 5'd3, 1'b0, 32'd0, 1'b0, 32'd0);
        expect_commit(2'd0, 5'd1, 32'h10, 4'd0, 1'b0, 32'd0);
        expect_commit(2'd0, 5'd2, 32'h11, 4'd1, 1'b0, 32'd0);
        expect_commit(2'd0, 5'd3, 32'h22, 4'd2, 1'b0, 32'd0);
        do_rs(4'd2, 32'h22);
        do_rs(4'd0, 32'h10);
        do_rs(4'd1, 32'h11);
        drain("t1_drain");
        chk("t1_tailTag", tailTag, 3);
        chk("t1_full", full, 0);

        // Fill to 16, blocked 17th, commit-cycle issue blocked, then alloc+commit.
        do_reset();
        for (int i = 0; i < 16; i++) do_issue(2'd0, 5'(i), 1'b0, 32'd0, 1'b0, 32'd0);
        chk("t2_full", full, 1);
        chk("t2_tailTag", tailTag, 0);
        do_issue(2'd0, 5'd17, 1'b0, 32'd0, 1'b0, 32'd0);
        chk("t2_17th_tail", tailTag, 0);
        chk("t2_17th_full", full, 1);
        expect_commit(2'd0, 5'd0, 32'hA0, 4'd0, 1'b0, 32'd0);
        expect_commit(2'd0, 5'd1, 32'hA1, 4'd1, 1'b0, 32'd0);
        do_rs(4'd0, 32'hA0);
        rsFlag = 1'b1; rsDest = 4'd1; rsVal = 32'hA1;
        do_issue(2'd0, 5'd20, 1'b0, 32'd0, 1'b0, 32'd0);
        rsFlag = 1'b0;
        chk("t2_commit_cycle_tail", tailTag, 0);
        chk("t2_commit_cycle_full", full, 0);
        do_issue(2'd0, 5'd21, 1'b0, 32'd0, 1'b0, 32'd0);
        chk("t2_alloc_commit_tail", tailTag, 1);
        chk("t2_alloc_commit_full", full, 0);
        do_issue(2'd0, 5'd22, 1'b0, 32'd0, 1'b0, 32'd0);
        chk("t2_refull_tail", tailTag, 2);
        chk("t2_refull_full", full, 1);
        drain("t2_drain");

        // Mispredicted branch flushes everything; same-cycle issue/writeback discarded.
        do_reset();
        do_issue(2'd1, 5'd0, 1'b0, 32'h100, 1'b0, 32'd0);
        do_issue(2'd0, 5'd5, 1'b0, 32'd0, 1'b0, 32'd0);
        do_issue(2'd0, 5'd6, 1'b0, 32'd0, 1'b0, 32'd0);
        expect_commit(2'd1, 5'd0, 32'h1, 4'd0, 1'b1, 32'h100);
        do_rs(4'd0, 32'h1);
        rsFlag = 1'b1; rsDest = 4'd1; rsVal = 32'h99;
        do_issue(2'd0, 5'd7, 1'b0, 32'd0, 1'b0, 32'd0);
        rsFlag = 1'b0;
        chk("t3_flushFlag", flushFlag, 1);
        chk("t3_flushPc", flushPc, 32'h100);
        chk("t3_tailTag", tailTag, 0);
        chk("t3_full", full, 0);
        tick();
        chk("t3_flush_pulse", flushFlag, 0);
        chk("t3_tail_after", tailTag, 0);
        drain("t3_drain");

        // Correctly predicted branch retires normally.
        do_reset();
        do_issue(2'd1, 5'd0, 1'b0, 32'h100, 1'b0, 32'd0);
        do_issue(2'd0, 5'd5, 1'b0, 32'd0, 1'b0, 32'd0);
        do_issue(2'd0, 5'd6, 1'b0, 32'd0, 1'b0, 32'd0);
        expect_commit(2'd1, 5'd0, 32'h0, 4'd0, 1'b0, 32'd0);
        expect_commit(2'd0, 5'd5, 32'h55, 4'd1, 1'b0, 32'd0);
        expect_commit(2'd0, 5'd6, 32'h66, 4'd2, 1'b0, 32'd0);
        do_rs(4'd0, 32'h0);
        do_rs(4'd1, 32'h55);
        do_rs(4'd2, 32'h66);
        drain("t4_drain");

        // Dual writeback with query bypass.
        do_reset();
        for (int i = 0; i < 6; i++) do_issue(2'd0, 5'(i + 1), 1'b0, 32'd0, 1'b0, 32'd0);
        queryJ = 4'd4; queryK = 4'd5;
        #1;
        chk("t5_pre_J_ready", queryJReady, 0);
        rsFlag = 1'b1; rsDest = 4'd4; rsVal = 32'h44;
        lsbFlag = 1'b1; lsbDest = 4'd5; lsbVal = 32'h55;
        #1;
        chk("t5_byp_J_ready", queryJReady, 1);
        chk("t5_byp_J_val", queryJVal, 32'h44);
        chk("t5_byp_K_ready", queryKReady, 1);
        chk("t5_byp_K_val", queryKVal, 32'h55);
        tick();
        rsFlag = 1'b0; lsbFlag = 1'b0;
        #1;
        chk("t5_st_J_ready", queryJReady, 1);
        chk("t5_st_J_val", queryJVal, 32'h44);
        chk("t5_st_K_ready", queryKReady, 1);
        chk("t5_st_K_val", queryKVal, 32'h55);
        drain("t5_drain");

        // readyIn hold, EXIT sticky, issue after exit, reset mid-run.
        do_reset();
        do_issue(2'd0, 5'd7, 1'b0, 32'd0, 1'b0, 32'd0);
        expect_commit(2'd0, 5'd7, 32'h77, 4'd0, 1'b0, 32'd0);
        do_rs(4'd0, 32'h77);
        readyIn = 1'b0;
        issueFlag = 1'b1; issueType = 2'd0; issueRd = 5'd8;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6_hold_commit", commitFlag, 0);
        end
        issueFlag = 1'b0;
        chk("t6_hold_tail", tailTag, 1);
        readyIn = 1'b1;
        tick();
        chk("t6_release_commit", commitFlag, 1);
        expect_commit(2'd3, 5'd0, 32'h0, 4'd1, 1'b0, 32'd0);
        expect_commit(2'd0, 5'd9, 32'h99, 4'd2, 1'b0, 32'd0);
        do_issue(2'd3, 5'd0, 1'b0, 32'd0, 1'b1, 32'h0);
        do_issue(2'd0, 5'd9, 1'b0, 32'd0, 1'b1, 32'h99);
        drain("t6_drain");
        chk("t6_exitFlag", exitFlag, 1);
        chk("t6_tail_after_exit", tailTag, 3);
        do_issue(2'd0, 5'd10, 1'b0, 32'd0, 1'b0, 32'd0);
        do_reset();
        chk("t6_rst_commitFlag", commitFlag, 0);
        chk("t6_rst_exitFlag", exitFlag, 0);
        chk("t6_rst_flushFlag", flushFlag, 0);
        chk("t6_rst_full", full, 0);
        chk("t6_rst_tailTag", tailTag, 0);
        chk("t6_rst_commitVal", commitVal, 0);
        chk("t6_rst_commitRd", commitRd, 0);
        chk("t6_rst_commitTag", commitTag, 0);
        chk("t6_rst_commitType", commitType, 0);
        chk("t6_rst_flushPc", flushPc, 0);

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
